axis_irq_req_initiator: RTL and testbench
=========================================

// Module: axis_irq_req_initiator
// PURPOSE
// - Initiator end of the AXIS IRQ request/response path. Converts per-vector interrupt events into AXIS IRQ
//   request beats, then consumes the matching IRQ response beats.
// - Tracks one outstanding request per vector and pulses a per-vector ack when its response returns.
// - Sits between the interrupt sources and the IRQ request pipeline. Its response input is fed by the
//   IRQ response pipeline register.
// PARAMETERS
// - NUM_VECTORS     4   number of interrupt vectors (1-32)
// - VID_W           2   vector-id field width, >= clog2(NUM_VECTORS), min 1
// - REQ_DW          16  IRQ request tdata width (> VID_W)
// - RSP_DW          16  IRQ response tdata width (> VID_W)
// - MAX_OUTSTANDING 4   max in-flight requests across all vectors (1..NUM_VECTORS)
// PORTS
// - clk               in   1            clock
// - rst               in   1            asynchronous reset, active-high
// - irq_in            in   NUM_VECTORS  interrupt event inputs; a rising edge requests an interrupt
// - irq_ack           out  NUM_VECTORS  1-cycle pulse when that vector's response is accepted
// - m_irq_req_tvalid  out  1            request beat valid
// - m_irq_req_tdata   out  REQ_DW       [VID_W-1:0] = vector id; upper bits 0
// - m_irq_req_tready  in   1            downstream ready
// - s_irq_rsp_tvalid  in   1            response beat valid
// - s_irq_rsp_tdata   in   RSP_DW       [VID_W-1:0] = vector id; upper bits ignored
// - s_irq_rsp_tready  out  1            response ready
// - outstanding_cnt   out  VID_W+1      number of vectors with a request in flight
// - err_unexp_rsp     out  1            1-cycle pulse on an unexpected or out-of-range response
// BEHAVIOUR
// Reset (async assert, sync deassert via clk domain)
// - All outputs are 0. pending/outstanding vectors are cleared and the round-robin pointer is set to 0.
// - The edge-detect history register resets to all 1s, so an irq_in already high at reset exit is NOT an event.
// - Reset asserted mid-operation drops any in-flight beat immediately and loses all pending state.
// Edge detect and pending
// - pending[i] is set on the cycle after irq_in[i] is sampled 1 while its previous sample was 0.
// - An event on an already-pending vector coalesces: no second request is issued.
// - An event while vector i is outstanding (and not pending) sets pending[i]. A new request for i is
//   issued only after i's response clears outstanding[i].
// Arbitration and transmit
// - Eligible set = pending & ~outstanding. Requires outstanding_cnt < MAX_OUTSTANDING and the tx
//   register empty, or being emptied this cycle (tvalid & tready).
// - Selection is round-robin, starting at the vector after the last grant, wrapping NUM_VECTORS-1 -> 0.
// - On grant: load tx register (tvalid=1 next cycle), clear pending[i], set outstanding[i], advance pointer.
// - Back-to-back beats are allowed: 1 beat/cycle with tready held high.
// - Latency: irq_in rising (first cycle high) = cycle N -> m_irq_req_tvalid=1 at N+2.
// - AXIS rules: once tvalid=1, tdata is held stable and tvalid is not dropped until tready=1.
//   tvalid never depends combinationally on tready.
// Response
// - s_irq_rsp_tready = 1 whenever not in reset; responses are never back-pressured.
// - Accepted beat with vid < NUM_VECTORS and outstanding[vid]=1: clear outstanding[vid] and pulse
//   irq_ack[vid] on the next cycle.
// - Otherwise the beat is dropped and err_unexp_rsp pulses on the next cycle; no state changes.
// Simultaneous events and timing
// - A response clearing vector i in the same cycle the arbiter evaluates is not seen by the arbiter.
//   Arbitration uses registered outstanding, so i becomes eligible the following cycle.
// - A grant and a response in the same cycle update outstanding_cnt by +1-1 = net 0.
// - outstanding_cnt is registered and equals popcount(outstanding).
// TESTING
// - Single event: irq_in[2] rises, tready=1 -> tvalid at +2 cycles with tdata=0x0002. Response vid 2 ->
//   irq_ack[2] pulses 1 cycle later; outstanding_cnt goes 0->1->0.
// - Round-robin: irq_in[3:0] all rise together, tready=1 -> beats with vids 0,1,2,3 on consecutive cycles.
//   After last grant=3 and new events on 0,3, order is 0 then 3.
// - Backpressure: tready=0 for 5 cycles with tvalid=1 -> tdata held at the same vid, no extra grants.
//   MAX_OUTSTANDING=2 with 4 events -> only 2 beats until a response arrives.
// - Coalesce and re-arm: two irq_in[1] pulses before grant -> 1 request. Pulse while outstanding ->
//   second request issued the cycle after the response is accepted.
// - Errors: response vid 1 with nothing outstanding, or vid 5 with NUM_VECTORS=4 -> err_unexp_rsp
//   pulses, irq_ack stays 0, outstanding_cnt unchanged.
// - Reset: assert rst with tvalid=1 and cnt=2 -> all outputs 0 immediately. irq_in held high across
//   reset release -> no request issued.

Source files
------------

// File: rtl/axis_irq_req_initiator.sv
// rtl/axis_irq_req_initiator.sv - interrupt events to AXIS IRQ request beats, with response tracking
// One request in flight per vector; round-robin grant into a single-entry tx register.
module axis_irq_req_initiator #(
    parameter int NUM_VECTORS     = 4,
    parameter int VID_W           = 2,
    parameter int REQ_DW          = 16,
    parameter int RSP_DW          = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_VECTORS-1:0] irq_in,
    output logic [NUM_VECTORS-1:0] irq_ack,
    output logic                   m_irq_req_tvalid,
    output logic [REQ_DW-1:0]      m_irq_req_tdata,
    input  logic                   m_irq_req_tready,
    input  logic                   s_irq_rsp_tvalid,
    input  logic [RSP_DW-1:0]      s_irq_rsp_tdata,
    output logic                   s_irq_rsp_tready,
    output logic [VID_W:0]         outstanding_cnt,
    output logic                   err_unexp_rsp
);
    localparam int CNT_W = VID_W + 1;

    logic [NUM_VECTORS-1:0] irq_prev;
    logic [NUM_VECTORS-1:0] pending;
    logic [NUM_VECTORS-1:0] outstanding;
    logic [NUM_VECTORS-1:0] irq_event;
    logic [NUM_VECTORS-1:0] eligible;
    logic [NUM_VECTORS-1:0] grant_mask;
    logic [NUM_VECTORS-1:0] rsp_clear;
    logic [VID_W-1:0]       rr_ptr;
    logic [VID_W-1:0]       grant_vid;
    logic [VID_W-1:0]       rsp_vid;
    logic                   grant;
    logic                   rsp_accept;
    logic                   rsp_hit;
    int                     idx;

    assign s_irq_rsp_tready = ~rst;
    assign irq_event        = irq_in & ~irq_prev;
    assign eligible         = pending & ~outstanding;
    assign rsp_vid          = s_irq_rsp_tdata[VID_W-1:0];
    assign rsp_accept       = s_irq_rsp_tvalid & s_irq_rsp_tready;

    // Round-robin search starting at rr_ptr; only when the tx slot is free or draining.
    always_comb begin
        grant     = 1'b0;
        grant_vid = '0;
        idx       = 0;
        if ((!m_irq_req_tvalid || m_irq_req_tready) &&
            (outstanding_cnt < CNT_W'(MAX_OUTSTANDING))) begin
            for (int k = 0; k < NUM_VECTORS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_VECTORS) idx = idx - NUM_VECTORS;
                if (!grant && eligible[idx]) begin
                    grant     = 1'b1;
                    grant_vid = VID_W'(idx);
                end
            end
        end
    end

    // Out-of-range ids never match a vector index, so they fall through to the error path.
    always_comb begin
        grant_mask = '0;
        rsp_clear  = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            grant_mask[i] = grant && (grant_vid == VID_W'(i));
            rsp_clear[i]  = rsp_accept && (rsp_vid == VID_W'(i)) && outstanding[i];
        end
        rsp_hit = |rsp_clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev         <= '1;
            pending          <= '0;
            outstanding      <= '0;
            outstanding_cnt  <= '0;
            rr_ptr           <= '0;
            irq_ack          <= '0;
            err_unexp_rsp    <= 1'b0;
            m_irq_req_tvalid <= 1'b0;
            m_irq_req_tdata  <= '0;
        end else begin
            irq_prev        <= irq_in;
            pending         <= (pending & ~grant_mask) | irq_event;
            outstanding     <= (outstanding | grant_mask) & ~rsp_clear;
            outstanding_cnt <= outstanding_cnt + CNT_W'(grant) - CNT_W'(rsp_hit);
            irq_ack         <= rsp_clear;
            err_unexp_rsp   <= rsp_accept && !rsp_hit;
            if (grant) begin
                m_irq_req_tvalid <= 1'b1;
                m_irq_req_tdata  <= REQ_DW'(grant_vid);
                if (int'(grant_vid) == NUM_VECTORS - 1) rr_ptr <= '0;
                else                                    rr_ptr <= grant_vid + 1'b1;
            end else if (m_irq_req_tready) begin
                m_irq_req_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_irq_req_initiator.sv
// tb/tb_axis_irq_req_initiator.sv - scoreboard bench for axis_irq_req_initiator
module tb_axis_irq_req_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_in = '0;
    logic [3:0]  irq_ack;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_data = '0;
    logic        rsp_ready;
    logic [3:0]  cnt;
    logic        err;

    logic [3:0]  irq2 = '0;
    logic [3:0]  ack2;
    logic        tvalid2;
    logic [15:0] tdata2;
    logic        rsp2_valid = 1'b0;
    logic [15:0] rsp2_data = '0;
    logic        rsp2_ready;
    logic [2:0]  cnt2;
    logic        err2;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    axis_irq_req_initiator #(.NUM_VECTORS(4), .VID_W(3), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_ack(irq_ack),
        .m_irq_req_tvalid(m_tvalid), .m_irq_req_tdata(m_tdata), .m_irq_req_tready(m_tready),
        .s_irq_rsp_tvalid(rsp_valid), .s_irq_rsp_tdata(rsp_data), .s_irq_rsp_tready(rsp_ready),
        .outstanding_cnt(cnt), .err_unexp_rsp(err)
    );

    axis_irq_req_initiator #(.NUM_VECTORS(4), .VID_W(2), .MAX_OUTSTANDING(2)) dut_m2 (
        .clk(clk), .rst(rst), .irq_in(irq2), .irq_ack(ack2),
        .m_irq_req_tvalid(tvalid2), .m_irq_req_tdata(tdata2), .m_irq_req_tready(1'b1),
        .s_irq_rsp_tvalid(rsp2_valid), .s_irq_rsp_tdata(rsp2_data), .s_irq_rsp_tready(rsp2_ready),
        .outstanding_cnt(cnt2), .err_unexp_rsp(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat monitor: inputs only change on negedges, so +2 sees what the next posedge samples.
    always @(negedge clk) begin
        #2;
        if (!rst && m_tvalid && m_tready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("beat_vid", 32'(m_tdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        irq_in = irq_in | m;
        @(negedge clk);
        irq_in = irq_in & ~m;
    endtask

    task automatic rsp(input logic [15:0] d, input logic [3:0] eack, input logic eerr);
        rsp_valid = 1'b1;
        rsp_data  = d;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rsp_ack", 32'(irq_ack), 32'(eack));
        chk("rsp_err", 32'(err), 32'(eerr));
    endtask

    task automatic do_reset;
        rst = 1'b1; irq_in = '0; m_tready = 1'b1; rsp_valid = 1'b0;
        cyc(2);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_tready", 32'(rsp_ready), 0);
        chk("rst_ack_err", 32'({irq_ack, err}), 0);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        int beats;
        logic [15:0] vid3;
        do_reset();
        chk("rsp_ready_up", 32'(rsp_ready), 1);

        // single event on vector 2
        exp_q.push_back(16'h0002);
        irq_in = 4'b0100;
        cyc(1); chk("lat_n1_tvalid", 32'(m_tvalid), 0);
        cyc(1); chk("lat_n2_tvalid", 32'(m_tvalid), 1); chk("single_cnt1", 32'(cnt), 1);
        irq_in = '0;
        cyc(1); chk("single_drained", 32'(m_tvalid), 0);
        rsp(16'h0002, 4'b0100, 1'b0);
        chk("single_cnt0", 32'(cnt), 0);
        cyc(1); chk("ack_one_cycle", 32'(irq_ack), 0);

        // round robin from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        irq_in = 4'hF;
        cyc(2);
        irq_in = '0;
        for (int i = 0; i < 4; i++) begin
            chk("rr_b2b_valid", 32'(m_tvalid), 1);
            cyc(1);
        end
        chk("rr_done", 32'(m_tvalid), 0);
        chk("rr_cnt4", 32'(cnt), 4);
        for (int i = 0; i < 4; i++) rsp(16'(i), 4'(1 << i), 1'b0);
        chk("rr_cnt0", 32'(cnt), 0);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0003);
        pulse(4'b1001);
        cyc(3);
        chk("rr_wrap_cnt", 32'(cnt), 2);
        rsp(16'h0000, 4'b0001, 1'b0);
        rsp(16'h0003, 4'b1000, 1'b0);

        // backpressure: pointer is 0, so vectors 1 then 2
        m_tready = 1'b0;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
        pulse(4'b0110);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(m_tvalid), 1);
            chk("bp_tdata", 32'(m_tdata), 1);
            chk("bp_cnt", 32'(cnt), 1);
            cyc(1);
        end
        m_tready = 1'b1;
        cyc(3);
        chk("bp_cnt2", 32'(cnt), 2);
        rsp(16'h0001, 4'b0010, 1'b0);
        rsp(16'h0002, 4'b0100, 1'b0);

        // coalesce two pulses on vector 1 while tx holds vector 0
        m_tready = 1'b0;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        pulse(4'b0001); cyc(1);
        pulse(4'b0010); cyc(1);
        pulse(4'b0010); cyc(1);
        chk("coal_hold_tdata", 32'(m_tdata), 0);
        m_tready = 1'b1;
        cyc(4);
        chk("coal_cnt", 32'(cnt), 2);
        chk("coal_idle", 32'(m_tvalid), 0);
        // re-arm while outstanding
        pulse(4'b0010);
        cyc(3);
        chk("rearm_wait", 32'(m_tvalid), 0);
        exp_q.push_back(16'h0001);
        rsp(16'h0001, 4'b0010, 1'b0);
        cyc(1);
        chk("rearm_issue", 32'(m_tvalid), 1);
        cyc(1);
        rsp(16'h0000, 4'b0001, 1'b0);
        rsp(16'h0001, 4'b0010, 1'b0);
        chk("coal_cnt0", 32'(cnt), 0);

        // unexpected and out-of-range responses
        rsp(16'h0001, 4'b0000, 1'b1);
        chk("err_cnt0", 32'(cnt), 0);
        rsp(16'h0005, 4'b0000, 1'b1);
        exp_q.push_back(16'h0003);
        pulse(4'b1000);
        cyc(2);
        chk("err_cnt1", 32'(cnt), 1);
        rsp(16'h0005, 4'b0000, 1'b1);
        chk("err_cnt_kept", 32'(cnt), 1);
        rsp(16'hA003, 4'b1000, 1'b0);
        chk("upper_ignored_cnt", 32'(cnt), 0);

        // reset mid-operation
        exp_q.push_back(16'h0000);
        pulse(4'b0001);
        cyc(3);
        m_tready = 1'b0;
        pulse(4'b0010);
        cyc(2);
        chk("pre_rst_valid", 32'(m_tvalid), 1);
        chk("pre_rst_cnt", 32'(cnt), 2);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(m_tvalid), 0);
        chk("async_rst_tdata", 32'(m_tdata), 0);
        chk("async_rst_cnt", 32'(cnt), 0);
        chk("async_rst_tready", 32'(rsp_ready), 0);
        irq_in = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        cyc(6);
        chk("held_high_valid", 32'(m_tvalid), 0);
        chk("held_high_cnt", 32'(cnt), 0);
        irq_in = '0;
        m_tready = 1'b1;

        // MAX_OUTSTANDING=2 instance
        beats = 0;
        irq2 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            irq2 = '0;
            if (tvalid2) beats++;
        end
        chk("m2_beats", 32'(beats), 2);
        chk("m2_cnt", 32'(cnt2), 2);
        rsp2_valid = 1'b1; rsp2_data = 16'h0000;
        @(negedge clk);
        rsp2_valid = 1'b0;
        chk("m2_ack", 32'(ack2), 1);
        beats = 0; vid3 = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tvalid2) begin beats++; vid3 = tdata2; end
        end
        chk("m2_beats_after", 32'(beats), 1);
        chk("m2_third_vid", 32'(vid3), 2);
        chk("m2_cnt_after", 32'(cnt2), 2);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
